// File: rtl/foxtrot_pkg.sv
// Shared widths, the issue-queue entry layout and the wakeup match helper.
package foxtrot_pkg;

   localparam int PRN_BITS     = 6;
   localparam int INST_ID_BITS = 6;
   localparam int MAX_OPERANDS = 3;
   localparam int ARN_BITS     = 5;

   typedef struct packed {
      logic                                   valid;
      logic [INST_ID_BITS-1:0]                inst_id;
      logic [31:0]                            raw_instr;
      logic [63:0]                            pc;
      logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]  src_prn;
      logic [MAX_OPERANDS-1:0]                src_valid;
      logic [MAX_OPERANDS-1:0]                src_ready;
      logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]  dst_prn;
      logic [MAX_OPERANDS-1:0]                dst_valid;
   } iq_entry_t;

   function automatic logic prn_hit(
      input logic [PRN_BITS-1:0]                 prn,
      input logic [MAX_OPERANDS-1:0]             lane_valid,
      input logic [MAX_OPERANDS-1:0][PRN_BITS-1:0] lane_prn
   );
      logic hit;
      hit = 1'b0;
      for (int l = 0; l < MAX_OPERANDS; l++) begin
         if (lane_valid[l] && (lane_prn[l] == prn)) hit = 1'b1;
      end
      return hit;
   endfunction

endpackage

// File: rtl/iq_select.sv
// Lowest-index priority picker: one-hot grant of the first set request bit.
module iq_select #(
   parameter int N = 8
) (
   input  logic [N-1:0] req,
   output logic [N-1:0] grant,
   output logic         any
);

   assign grant = req & (~req + N'(1));
   assign any   = |req;

endmodule

// File: rtl/issue_queue.sv
// Per-FU compacting issue queue: oldest entry at index 0, wakeup snooping,
// oldest-ready select with valid/ready issue handshake and full flush.
module issue_queue
   import foxtrot_pkg::*;
#(
   parameter int QUEUE_SIZE = 8
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   enq_valid,
   output logic                                   enq_ready,
   input  logic [INST_ID_BITS-1:0]                enq_inst_id,
   input  logic [31:0]                            enq_raw_instr,
   input  logic [63:0]                            enq_instr_pc,
   input  logic [MAX_OPERANDS-1:0]                enq_prn_input_valid,
   input  logic [MAX_OPERANDS-1:0]                enq_prn_input_ready,
   input  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]  enq_prn_input,
   input  logic [MAX_OPERANDS-1:0]                enq_prn_output_valid,
   input  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]  enq_prn_output,
   input  logic [MAX_OPERANDS-1:0]                set_prn_ready_valid,
   input  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]  set_prn_ready,
   input  logic                                   flush,
   output logic                                   iss_valid,
   input  logic                                   iss_ready,
   output logic [INST_ID_BITS-1:0]                iss_inst_id,
   output logic [31:0]                            iss_raw_instr,
   output logic [63:0]                            iss_instr_pc,
   output logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]  iss_prn_input,
   output logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]  iss_prn_output,
   output logic [MAX_OPERANDS-1:0]                iss_prn_output_valid,
   output logic [$clog2(QUEUE_SIZE):0]            count
);

   localparam int CW = $clog2(QUEUE_SIZE) + 1;

   iq_entry_t               q      [QUEUE_SIZE];
   iq_entry_t               q_nxt  [QUEUE_SIZE];
   iq_entry_t               woken  [QUEUE_SIZE+1];
   iq_entry_t               sel;
   iq_entry_t               new_e;
   logic [CW-1:0]           count_q;
   logic [CW-1:0]           count_nxt;
   logic [CW-1:0]           sel_pos;
   logic [CW-1:0]           wr_pos;
   logic [QUEUE_SIZE-1:0]   req;
   logic [QUEUE_SIZE-1:0]   grant;
   logic                    sel_any;
   logic                    enq_fire;
   logic                    iss_fire;

   always_comb begin
      req = '0;
      for (int i = 0; i < QUEUE_SIZE; i++) begin
         req[i] = q[i].valid && (&q[i].src_ready);
      end
   end

   iq_select #(.N(QUEUE_SIZE)) u_select (
      .req   (req),
      .grant (grant),
      .any   (sel_any)
   );

   // Grant is one-hot, so OR-reduction doubles as a mux and an encoder.
   always_comb begin
      sel     = '0;
      sel_pos = '0;
      for (int i = 0; i < QUEUE_SIZE; i++) begin
         if (grant[i]) begin
            sel     = sel | q[i];
            sel_pos = sel_pos | CW'(i);
         end
      end
   end

   assign iss_valid            = sel_any;
   assign iss_inst_id          = sel.inst_id;
   assign iss_raw_instr        = sel.raw_instr;
   assign iss_instr_pc         = sel.pc;
   assign iss_prn_input        = sel.src_prn;
   assign iss_prn_output       = sel.dst_prn;
   assign iss_prn_output_valid = sel.dst_valid;

   assign enq_ready = (count_q != CW'(QUEUE_SIZE));
   assign enq_fire  = enq_valid && enq_ready;
   assign iss_fire  = sel_any && iss_ready;
   assign wr_pos    = count_q - CW'(iss_fire);
   assign count     = count_q;

   always_comb begin
      new_e           = '0;
      new_e.valid     = 1'b1;
      new_e.inst_id   = enq_inst_id;
      new_e.raw_instr = enq_raw_instr;
      new_e.pc        = enq_instr_pc;
      new_e.src_prn   = enq_prn_input;
      new_e.src_valid = enq_prn_input_valid;
      new_e.dst_prn   = enq_prn_output;
      new_e.dst_valid = enq_prn_output_valid;
      for (int k = 0; k < MAX_OPERANDS; k++) begin
         new_e.src_ready[k] = !enq_prn_input_valid[k] || enq_prn_input_ready[k] ||
                              prn_hit(enq_prn_input[k], set_prn_ready_valid, set_prn_ready);
      end
   end

   // Wake first, then shift over the issued slot, then land the new entry.
   always_comb begin
      for (int i = 0; i < QUEUE_SIZE; i++) begin
         woken[i] = q[i];
         for (int k = 0; k < MAX_OPERANDS; k++) begin
            if (q[i].valid && q[i].src_valid[k] && !q[i].src_ready[k] &&
                prn_hit(q[i].src_prn[k], set_prn_ready_valid, set_prn_ready)) begin
               woken[i].src_ready[k] = 1'b1;
            end
         end
      end
      woken[QUEUE_SIZE] = '0;
      for (int i = 0; i < QUEUE_SIZE; i++) begin
         q_nxt[i] = (iss_fire && (CW'(i) >= sel_pos)) ? woken[i+1] : woken[i];
         if (enq_fire && (CW'(i) == wr_pos)) q_nxt[i] = new_e;
         if (flush) q_nxt[i] = '0;
      end
      count_nxt = flush ? '0 : (count_q + CW'(enq_fire) - CW'(iss_fire));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < QUEUE_SIZE; i++) q[i] <= '0;
         count_q <= '0;
      end else begin
         for (int i = 0; i < QUEUE_SIZE; i++) q[i] <= q_nxt[i];
         count_q <= count_nxt;
      end
   end

endmodule

// File: tb/tb_issue_queue.sv
// Directed and randomized checks of issue_queue against a queue-based age-order model.
module tb_issue_queue;

   localparam int QS = 8;
   localparam int MO = 3;
   localparam int PB = 6;
   localparam int IB = 6;
   localparam int CW = 4;

   logic                   clk;
   logic                   rst;
   logic                   enq_valid;
   logic                   enq_ready;
   logic [IB-1:0]          enq_inst_id;
   logic [31:0]            enq_raw_instr;
   logic [63:0]            enq_instr_pc;
   logic [MO-1:0]          enq_prn_input_valid;
   logic [MO-1:0]          enq_prn_input_ready;
   logic [MO-1:0][PB-1:0]  enq_prn_input;
   logic [MO-1:0]          enq_prn_output_valid;
   logic [MO-1:0][PB-1:0]  enq_prn_output;
   logic [MO-1:0]          set_prn_ready_valid;
   logic [MO-1:0][PB-1:0]  set_prn_ready;
   logic                   flush;
   logic                   iss_valid;
   logic                   iss_ready;
   logic [IB-1:0]          iss_inst_id;
   logic [31:0]            iss_raw_instr;
   logic [63:0]            iss_instr_pc;
   logic [MO-1:0][PB-1:0]  iss_prn_input;
   logic [MO-1:0][PB-1:0]  iss_prn_output;
   logic [MO-1:0]          iss_prn_output_valid;
   logic [CW-1:0]          count;

   issue_queue #(.QUEUE_SIZE(QS)) dut (
      .clk                  (clk),
      .rst                  (rst),
      .enq_valid            (enq_valid),
      .enq_ready            (enq_ready),
      .enq_inst_id          (enq_inst_id),
      .enq_raw_instr        (enq_raw_instr),
      .enq_instr_pc         (enq_instr_pc),
      .enq_prn_input_valid  (enq_prn_input_valid),
      .enq_prn_input_ready  (enq_prn_input_ready),
      .enq_prn_input        (enq_prn_input),
      .enq_prn_output_valid (enq_prn_output_valid),
      .enq_prn_output       (enq_prn_output),
      .set_prn_ready_valid  (set_prn_ready_valid),
      .set_prn_ready        (set_prn_ready),
      .flush                (flush),
      .iss_valid            (iss_valid),
      .iss_ready            (iss_ready),
      .iss_inst_id          (iss_inst_id),
      .iss_raw_instr        (iss_raw_instr),
      .iss_instr_pc         (iss_instr_pc),
      .iss_prn_input        (iss_prn_input),
      .iss_prn_output       (iss_prn_output),
      .iss_prn_output_valid (iss_prn_output_valid),
      .count                (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [IB-1:0]          id;
      logic [31:0]            instr;
      logic [63:0]            pc;
      logic [MO-1:0][PB-1:0]  src;
      logic [MO-1:0]          rdy;
      logic [MO-1:0][PB-1:0]  dst;
      logic [MO-1:0]          dv;
   } m_t;

   m_t mq[$];
   int pass_cnt  = 0;
   int total_cnt = 0;

   function automatic int model_sel();
      for (int i = 0; i < mq.size(); i++) if (&mq[i].rdy) return i;
      return -1;
   endfunction

   function automatic logic lane_hit(input logic [PB-1:0] p);
      for (int l = 0; l < MO; l++) if (set_prn_ready_valid[l] && set_prn_ready[l] == p) return 1'b1;
      return 1'b0;
   endfunction

   // Model step: evaluate the current inputs, advance one clock, commit.
   task automatic cycle();
      int   s;
      logic efire, ifire;
      m_t   n;
      m_t   nq[$];
      s     = model_sel();
      efire = enq_valid && (mq.size() < QS);
      ifire = (s >= 0) && iss_ready;
      n.id = enq_inst_id; n.instr = enq_raw_instr; n.pc = enq_instr_pc;
      n.src = enq_prn_input; n.dst = enq_prn_output; n.dv = enq_prn_output_valid;
      for (int k = 0; k < MO; k++)
         n.rdy[k] = !enq_prn_input_valid[k] || enq_prn_input_ready[k] || lane_hit(enq_prn_input[k]);
      nq = mq;
      if (flush) nq.delete();
      else begin
         if (ifire) nq.delete(s);
         foreach (nq[i])
            for (int k = 0; k < MO; k++)
               if (!nq[i].rdy[k] && lane_hit(nq[i].src[k])) nq[i].rdy[k] = 1'b1;
         if (efire) nq.push_back(n);
      end
      @(posedge clk);
      mq = nq;
      #1;
   endtask

   task automatic idle();
      enq_valid = 0; enq_inst_id = '0; enq_raw_instr = '0; enq_instr_pc = '0;
      enq_prn_input_valid = '0; enq_prn_input_ready = '0; enq_prn_input = '0;
      enq_prn_output_valid = '0; enq_prn_output = '0;
      set_prn_ready_valid = '0; set_prn_ready = '0; flush = 0; iss_ready = 0;
   endtask

   task automatic put(input logic [IB-1:0] id, input logic [MO-1:0][PB-1:0] src,
                      input logic [MO-1:0] sv, input logic [MO-1:0] sr);
      enq_valid = 1; enq_inst_id = id;
      enq_raw_instr = 32'hC0DE_0000 | 32'(id);
      enq_instr_pc  = 64'h8000_0000 + 64'(id) * 4;
      enq_prn_input = src; enq_prn_input_valid = sv; enq_prn_input_ready = sr;
      enq_prn_output = '0; enq_prn_output[0] = PB'(id) ^ 6'h2A; enq_prn_output_valid = 3'b001;
   endtask

   task automatic wake(input int lane, input logic [PB-1:0] prn);
      set_prn_ready_valid[lane] = 1'b1;
      set_prn_ready[lane] = prn;
   endtask

   task automatic test_reset();
      idle(); rst = 0;
      #2;
      total_cnt++; if (count !== 4'd0) $display("FAIL reset_count: got %0d want 0", count); else pass_cnt++;
      total_cnt++; if (enq_ready !== 1'b1) $display("FAIL reset_enq_ready: got %b want 1", enq_ready); else pass_cnt++;
      total_cnt++; if (iss_valid !== 1'b0) $display("FAIL reset_iss_valid: got %b want 0", iss_valid); else pass_cnt++;
      total_cnt++; if (iss_inst_id !== '0 || iss_instr_pc !== '0)
         $display("FAIL reset_payload: got id=%0d pc=%h want 0", iss_inst_id, iss_instr_pc); else pass_cnt++;
      #10 rst = 1;
   endtask

   task automatic test_basic_issue();
      put(6'd5, '0, 3'b000, 3'b000);
      cycle(); idle();
      total_cnt++; if (count !== 4'd1) $display("FAIL basic_count1: got %0d want 1", count); else pass_cnt++;
      total_cnt++; if (iss_valid !== 1'b1 || iss_inst_id !== 6'd5)
         $display("FAIL basic_issue: got v=%b id=%0d want v=1 id=5", iss_valid, iss_inst_id); else pass_cnt++;
      total_cnt++; if (iss_instr_pc !== 64'h8000_0014 || iss_raw_instr !== 32'hC0DE_0005)
         $display("FAIL basic_payload: got pc=%h instr=%h want 80000014 c0de0005", iss_instr_pc, iss_raw_instr); else pass_cnt++;
      iss_ready = 1;
      cycle(); idle();
      total_cnt++; if (count !== 4'd0 || iss_valid !== 1'b0)
         $display("FAIL basic_drain: got count=%0d v=%b want 0 0", count, iss_valid); else pass_cnt++;
   endtask

   task automatic test_wakeup_latency();
      put(6'd7, {6'd0, 6'd0, 6'd12}, 3'b001, 3'b000);
      cycle(); idle();
      total_cnt++; if (iss_valid !== 1'b0) $display("FAIL wake_pre1: got %b want 0", iss_valid); else pass_cnt++;
      cycle();
      wake(1, 6'd12);
      #1;
      total_cnt++; if (iss_valid !== 1'b0) $display("FAIL wake_no_bypass: got %b want 0", iss_valid); else pass_cnt++;
      cycle(); idle();
      total_cnt++; if (iss_valid !== 1'b1 || iss_inst_id !== 6'd7)
         $display("FAIL wake_issue: got v=%b id=%0d want v=1 id=7", iss_valid, iss_inst_id); else pass_cnt++;
      iss_ready = 1;
      cycle(); idle();
      total_cnt++; if (count !== 4'd0) $display("FAIL wake_drain: got %0d want 0", count); else pass_cnt++;
   endtask

   task automatic test_age_order();
      put(6'd3, {6'd0, 6'd0, 6'd9}, 3'b001, 3'b000);
      cycle();
      put(6'd4, '0, 3'b000, 3'b000);
      cycle(); idle();
      total_cnt++; if (iss_valid !== 1'b1 || iss_inst_id !== 6'd4)
         $display("FAIL age_ready_first: got v=%b id=%0d want v=1 id=4", iss_valid, iss_inst_id); else pass_cnt++;
      iss_ready = 1;
      put(6'd6, '0, 3'b000, 3'b000);
      cycle(); idle();
      total_cnt++; if (count !== 4'd2 || iss_inst_id !== 6'd6)
         $display("FAIL age_after_issue: got count=%0d id=%0d want 2 6", count, iss_inst_id); else pass_cnt++;
      wake(0, 6'd9);
      cycle(); idle();
      total_cnt++; if (iss_valid !== 1'b1 || iss_inst_id !== 6'd3)
         $display("FAIL age_oldest_wins: got v=%b id=%0d want v=1 id=3", iss_valid, iss_inst_id); else pass_cnt++;
      iss_ready = 1;
      cycle(); idle();
      total_cnt++; if (iss_inst_id !== 6'd6) $display("FAIL age_second: got id=%0d want 6", iss_inst_id); else pass_cnt++;
      iss_ready = 1;
      cycle(); idle();
      total_cnt++; if (count !== 4'd0) $display("FAIL age_drain: got %0d want 0", count); else pass_cnt++;
   endtask

   task automatic test_full();
      for (int i = 0; i < QS; i++) begin
         put(IB'(10 + i), {6'd0, 6'd0, PB'(40 + i)}, 3'b001, 3'b000);
         cycle();
      end
      idle();
      total_cnt++; if (count !== 4'd8 || enq_ready !== 1'b0)
         $display("FAIL full_state: got count=%0d rdy=%b want 8 0", count, enq_ready); else pass_cnt++;
      put(6'd60, '0, 3'b000, 3'b000);
      cycle(); idle();
      total_cnt++; if (count !== 4'd8 || iss_valid !== 1'b0)
         $display("FAIL full_ignore: got count=%0d v=%b want 8 0", count, iss_valid); else pass_cnt++;
      wake(2, 6'd43);
      cycle(); idle();
      total_cnt++; if (iss_valid !== 1'b1 || iss_inst_id !== 6'd13)
         $display("FAIL full_wake: got v=%b id=%0d want v=1 id=13", iss_valid, iss_inst_id); else pass_cnt++;
      iss_ready = 1;
      put(6'd61, '0, 3'b000, 3'b000);
      cycle(); idle();
      total_cnt++; if (count !== 4'd7 || enq_ready !== 1'b1 || iss_valid !== 1'b0)
         $display("FAIL full_no_passthru: got count=%0d rdy=%b v=%b want 7 1 0", count, enq_ready, iss_valid); else pass_cnt++;
      flush = 1;
      cycle(); idle();
   endtask

   task automatic test_flush();
      for (int i = 0; i < 4; i++) begin
         put(IB'(20 + i), {6'd0, 6'd0, PB'(50 + i)}, 3'b001, IB'(i % 2) == 0 ? 3'b001 : 3'b000);
         cycle();
      end
      idle();
      total_cnt++; if (count !== 4'd4) $display("FAIL flush_pre: got %0d want 4", count); else pass_cnt++;
      flush = 1; iss_ready = 1;
      put(6'd24, '0, 3'b000, 3'b000);
      cycle(); idle();
      total_cnt++; if (count !== 4'd0 || iss_valid !== 1'b0)
         $display("FAIL flush_clear: got count=%0d v=%b want 0 0", count, iss_valid); else pass_cnt++;
   endtask

   task automatic test_enq_bypass();
      put(6'd25, {6'd0, 6'd0, 6'd20}, 3'b001, 3'b000);
      wake(0, 6'd20);
      cycle(); idle();
      total_cnt++; if (iss_valid !== 1'b1 || iss_inst_id !== 6'd25)
         $display("FAIL bypass_issue: got v=%b id=%0d want v=1 id=25", iss_valid, iss_inst_id); else pass_cnt++;
      iss_ready = 1;
      cycle(); idle();
      total_cnt++; if (count !== 4'd0) $display("FAIL bypass_drain: got %0d want 0", count); else pass_cnt++;
   endtask

   task automatic test_random();
      int s;
      for (int c = 0; c < 600; c++) begin
         idle();
         if ($urandom_range(2) != 0) begin
            put(IB'($urandom), '0, 3'($urandom), 3'($urandom) & 3'($urandom));
            for (int k = 0; k < MO; k++) enq_prn_input[k] = PB'($urandom_range(15));
            enq_prn_output = MO*PB'($urandom); enq_prn_output_valid = 3'($urandom);
            enq_raw_instr = $urandom; enq_instr_pc = {$urandom, $urandom};
         end
         for (int l = 0; l < MO; l++) if ($urandom_range(2) == 0) wake(l, PB'($urandom_range(15)));
         iss_ready = 1'($urandom);
         flush = ($urandom_range(49) == 0);
         #1;
         s = model_sel();
         total_cnt++; if (count !== CW'(mq.size()) || enq_ready !== (mq.size() < QS))
            $display("FAIL rand_count: got count=%0d rdy=%b want %0d %b", count, enq_ready, mq.size(), mq.size() < QS); else pass_cnt++;
         total_cnt++; if (iss_valid !== (s >= 0))
            $display("FAIL rand_iss_valid: got %b want %b", iss_valid, s >= 0); else pass_cnt++;
         if (s >= 0) begin
            total_cnt++;
            if (iss_inst_id !== mq[s].id || iss_raw_instr !== mq[s].instr || iss_instr_pc !== mq[s].pc ||
                iss_prn_input !== mq[s].src || iss_prn_output !== mq[s].dst || iss_prn_output_valid !== mq[s].dv)
               $display("FAIL rand_payload: got id=%0d pc=%h src=%h want id=%0d pc=%h src=%h",
                        iss_inst_id, iss_instr_pc, iss_prn_input, mq[s].id, mq[s].pc, mq[s].src);
            else pass_cnt++;
         end else begin
            total_cnt++;
            if (iss_inst_id !== '0 || iss_instr_pc !== '0 || iss_raw_instr !== '0)
               $display("FAIL rand_idle_payload: got id=%0d pc=%h want 0 0", iss_inst_id, iss_instr_pc);
            else pass_cnt++;
         end
         cycle();
      end
      idle();
   endtask

   task automatic test_async_reset();
      put(6'd30, '0, 3'b000, 3'b000);
      cycle();
      put(6'd31, {6'd0, 6'd0, 6'd5}, 3'b001, 3'b000);
      cycle(); idle();
      #3 rst = 0;
      #1;
      mq.delete();
      total_cnt++; if (count !== 4'd0 || iss_valid !== 1'b0 || enq_ready !== 1'b1)
         $display("FAIL async_reset: got count=%0d v=%b rdy=%b want 0 0 1", count, iss_valid, enq_ready); else pass_cnt++;
      #2 rst = 1;
      cycle();
      total_cnt++; if (count !== 4'd0 || iss_valid !== 1'b0)
         $display("FAIL async_reset_hold: got count=%0d v=%b want 0 0", count, iss_valid); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_basic_issue();
      test_wakeup_latency();
      test_age_order();
      test_full();
      test_flush();
      test_enq_bypass();
      test_random();
      test_async_reset();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
